verificador_pista_param: RTL
============================

# verificador_pista_param

Parametrised track-sequence checker for the robot-track design. A robot reports one digit per `insere` pulse; the block compares it against a stored track of up to `LEN` digits, tolerates up to `MAX_ERROS-1` wrong digits, and ends in total success, partial success or failure. Outcome and progress appear on a 7-segment display and an error LED. It replaces the fixed 6-digit checker as the top-level state block and keeps its state set and display role.

## Interface
- `DIGIT_W`, 4: width of one track digit.
- `LEN`, 6: track length (maximum length when loadable), 1..16.
- `MAX_ERROS`, 3: wrong-digit count that forces failure, ≥1.
- `PISTA_PADRAO`, 24'h590060: default track, `LEN*DIGIT_W` bits, digit 0 in the MS nibble.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `numero`  in  DIGIT_W  digit reported by the robot, or digit to load.
- `insere`  in  1  insert strobe (level; rising edge detected internally).
- `carrega`  in  1  load strobe (only with `PISTA_CARREGAVEL_EN`; ignored otherwise).
- `reinicia`  in  1  synchronous return to INICIAL, keeping the stored track.
- `ledErro`  out  1  last accepted digit was wrong.
- `display`  out  7  segments {g,f,e,d,c,b,a}, active-high.
- `posicao`  out  $clog2(LEN+1)  index of the next expected digit.
- `erros`  out  $clog2(MAX_ERROS+1)  count of wrong digits.
- `estado`  out  3  state code.

## Operation
- States: INICIAL=0, VERIFICACAO=1, SUCESSO_TOTAL=2, SUCESSO_PARCIAL=3, FALHA=4.
- Accept event `acc` = `insere & ~insere_q`, where `insere_q` is `insere` registered. A held level therefore counts as one event.
- INICIAL + `acc` with `comprimento > 0`: move to VERIFICACAO and evaluate `numero` as digit 0 on the same event.
  - With `comprimento == 0`: ignore the event.
- Evaluation on `acc` in INICIAL or VERIFICACAO:
  - **Match** (`numero == pista[posicao]`): `posicao+1`, `ledErro`←0.
    - If the new `posicao == comprimento`: go to SUCESSO_TOTAL if `erros == 0`, else to SUCESSO_PARCIAL.
  - **Mismatch**: `posicao` holds, `erros+1`, `ledErro`←1.
    - If the new `erros == MAX_ERROS`: go to FALHA.
- Terminal states (2, 3, 4): `acc` is ignored. `ledErro` holds its last value.
- `reinicia` in any state: next edge sets INICIAL, `posicao`=0, `erros`=0, `ledErro`=0, and clears `insere_q`. It has priority over `acc` in the same cycle.
- Display by state:
  - INICIAL: dash 7'b1000000.
  - VERIFICACAO: decimal digit of `posicao`; values ≥10 show hex A–F in standard encoding.
  - SUCESSO_TOTAL: 'S' 7'b1101101.
  - SUCESSO_PARCIAL: 'P' 7'b1110011.
  - FALHA: 'F' 7'b1110001.
- `display` is decoded combinationally from registered state and `posicao`.

## Timing
- On `reset` low, asynchronously: state INICIAL, `posicao`=0, `erros`=0, `ledErro`=0, `insere_q`=0, `display`=7'b1000000.
  - With the macro: `comprimento`=0.
  - Without the macro: `comprimento`=LEN and track = `PISTA_PADRAO`.
- Reset may arrive mid-track and takes effect immediately; it is released synchronously by the environment.
- Latency: `insere` rises at edge N-1 setup and is sampled at edge N. State, `posicao`, `erros`, `ledErro` and `estado` are updated at edge N; `display` is valid after edge N.
- Minimum spacing between events: `insere` low for ≥1 cycle.
- Counters never exceed `comprimento` or `MAX_ERROS`; no wrap-around.

## Configuration
- `PISTA_CARREGAVEL_EN` defined:
  - In INICIAL with `comprimento < LEN`, a sampled `carrega` high writes `numero` into slot `comprimento` and increments `comprimento`. Each cycle high loads one digit.
  - The first load of a session (`comprimento` was 0) starts a new track.
  - Loads when full or outside INICIAL are ignored.
  - `carrega` and `acc` in the same cycle: the load wins and the insert is dropped.
- `PISTA_CARREGAVEL_EN` undefined: the track is constant `PISTA_PADRAO` and `comprimento` = LEN. `carrega` is unused and no storage is inferred.

## Test plan
- Default track, no macro: insert 5,9,0,0,6,0 → `posicao` 1..6, `ledErro`=0, state 2, display 7'b1101101.
- Insert 5,3,9,0,0,6,0 → after the 3: `ledErro`=1, `erros`=1, `posicao`=1. Final state 3, display 'P'.
- Insert 5,1,2,3 → `erros` reaches 3 on the third wrong digit, state 4, display 'F`. A further `insere` changes nothing.
- Hold `insere` high 5 cycles with `numero`=5 → exactly one accept, `posicao`=1. Then pull `reset` low mid-track → all outputs return to reset values in the same cycle.
- Macro on: load 7,2 with `carrega`, then insert 7,2 → `comprimento`=2, state 2. Assert `reinicia`, insert 7,2 again → state 2 again.
- Macro on, `comprimento`=0: `insere` ignored, state stays 0. Load 16 digits with `LEN`=16: the 17th load is ignored.

Source files
------------

// File: rtl/verificador_pista_param.sv
`default_nettype none
// ============================================================================
// Module   : verificador_pista_param
// Brief    : Parametrised robot-track checker with 7-segment outcome display.
//            Macro PISTA_CARREGAVEL_EN makes the track loadable via carrega.
// Revision : 1.0
// ============================================================================
module verificador_pista_param #(
  parameter int                      DIGIT_W      = 4,
  parameter int                      LEN          = 6,
  parameter int                      MAX_ERROS    = 3,
  parameter logic [LEN*DIGIT_W-1:0]  PISTA_PADRAO = 24'h590060
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DIGIT_W-1:0]               numero,
  input  logic                             insere,
  input  logic                             carrega,
  input  logic                             reinicia,
  output logic                             ledErro,
  output logic [6:0]                       display,
  output logic [$clog2(LEN+1)-1:0]         posicao,
  output logic [$clog2(MAX_ERROS+1)-1:0]   erros,
  output logic [2:0]                       estado
);

  localparam int PW    = $clog2(LEN+1);
  localparam int EW    = $clog2(MAX_ERROS+1);
  localparam int NSLOT = 2**PW;

  localparam logic [2:0] INICIAL         = 3'd0;
  localparam logic [2:0] VERIFICACAO     = 3'd1;
  localparam logic [2:0] SUCESSO_TOTAL   = 3'd2;
  localparam logic [2:0] SUCESSO_PARCIAL = 3'd3;
  localparam logic [2:0] FALHA           = 3'd4;

  logic [2:0]         r_estado, w_estado_prox;
  logic [PW-1:0]      r_posicao, w_pos_inc, w_comprimento;
  logic [EW-1:0]      r_erros, w_err_inc;
  logic               r_led, r_insere_q;
  logic [DIGIT_W-1:0] w_digito;
  logic               w_acc, w_carga, w_avalia, w_match;
  logic [PW+15:0]     w_pos_ext;

`ifdef PISTA_CARREGAVEL_EN
  logic [PW-1:0]      r_comprimento;
  logic [DIGIT_W-1:0] r_pista [NSLOT];

  assign w_carga = carrega && (r_estado == INICIAL) && (r_comprimento < PW'(LEN));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_comprimento <= '0;
    else if (w_carga) r_comprimento <= r_comprimento + PW'(1);
  end

  // Track storage needs no reset: slots are only read below comprimento.
  always_ff @(posedge clk) begin
    if (w_carga) r_pista[r_comprimento] <= numero;
  end

  assign w_comprimento = r_comprimento;
  assign w_digito      = r_pista[r_posicao];
`else
  logic [DIGIT_W-1:0] w_pista [NSLOT];
  logic               w_unused_carrega;

  for (genvar i = 0; i < NSLOT; i++) begin : g_pista
    if (i < LEN) begin : g_dig
      assign w_pista[i] = PISTA_PADRAO[(LEN-1-i)*DIGIT_W +: DIGIT_W];
    end else begin : g_vazio
      assign w_pista[i] = '0;
    end
  end

  assign w_carga          = 1'b0;
  assign w_comprimento    = PW'(LEN);
  assign w_digito         = w_pista[r_posicao];
  assign w_unused_carrega = carrega;
`endif

  // A load in the same cycle swallows the insert.
  assign w_acc     = insere & ~r_insere_q & ~w_carga;
  assign w_avalia  = w_acc && (((r_estado == INICIAL) && (w_comprimento != '0)) ||
                               (r_estado == VERIFICACAO));
  assign w_match   = (numero == w_digito);
  assign w_pos_inc = r_posicao + PW'(1);
  assign w_err_inc = r_erros + EW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_estado <= INICIAL;
    else        r_estado <= w_estado_prox;
  end

  always_comb begin
    w_estado_prox = r_estado;
    if (reinicia) begin
      w_estado_prox = INICIAL;
    end else if (w_avalia) begin
      if (w_match) begin
        if (w_pos_inc == w_comprimento)
          w_estado_prox = (r_erros == '0) ? SUCESSO_TOTAL : SUCESSO_PARCIAL;
        else
          w_estado_prox = VERIFICACAO;
      end else begin
        w_estado_prox = (w_err_inc == EW'(MAX_ERROS)) ? FALHA : VERIFICACAO;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_posicao  <= '0;
      r_erros    <= '0;
      r_led      <= 1'b0;
      r_insere_q <= 1'b0;
    end else if (reinicia) begin
      r_posicao  <= '0;
      r_erros    <= '0;
      r_led      <= 1'b0;
      r_insere_q <= 1'b0;
    end else begin
      r_insere_q <= insere;
      if (w_avalia) begin
        if (w_match) begin
          r_posicao <= w_pos_inc;
          r_led     <= 1'b0;
        end else begin
          r_erros   <= w_err_inc;
          r_led     <= 1'b1;
        end
      end
    end
  end

  assign w_pos_ext = {16'd0, r_posicao};

  // Segment order {g,f,e,d,c,b,a}, active-high.
  always_comb begin
    display = 7'b1000000;
    case (r_estado)
      VERIFICACAO: begin
        case (w_pos_ext[3:0])
          4'h0: display = 7'b0111111;
          4'h1: display = 7'b0000110;
          4'h2: display = 7'b1011011;
          4'h3: display = 7'b1001111;
          4'h4: display = 7'b1100110;
          4'h5: display = 7'b1101101;
          4'h6: display = 7'b1111101;
          4'h7: display = 7'b0000111;
          4'h8: display = 7'b1111111;
          4'h9: display = 7'b1101111;
          4'hA: display = 7'b1110111;
          4'hB: display = 7'b1111100;
          4'hC: display = 7'b0111001;
          4'hD: display = 7'b1011110;
          4'hE: display = 7'b1111001;
          default: display = 7'b1110001;
        endcase
      end
      SUCESSO_TOTAL:   display = 7'b1101101;
      SUCESSO_PARCIAL: display = 7'b1110011;
      FALHA:           display = 7'b1110001;
      default:         display = 7'b1000000;
    endcase
  end

  assign estado  = r_estado;
  assign posicao = r_posicao;
  assign erros   = r_erros;
  assign ledErro = r_led;

endmodule
`default_nettype wire
